fir_cfg_sequencer: RTL
======================

FIR_CFG_SEQUENCER -- requirements
Module: fir_cfg_sequencer

Interface
REQ-001 SHALL have parameter N_COEF, default 128, number of coefficients per bank (power of two).
REQ-002 SHALL have parameter COEFF_SIZE, default 16, coefficient word width.
REQ-003 SHALL have parameter BANK_W, default 2, bank-select width.
REQ-004 SHALL have parameter DRAIN_CYC, default 64, clk cycles data is blocked before a reload.
REQ-005 SHALL have port clk  input  1  clock, all logic on its rising edge.
REQ-006 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle reload request.
REQ-008 SHALL have port bank  input  BANK_W  bank to load, sampled with an accepted start.
REQ-009 SHALL have port rom_addr  output  BANK_W+log2(N_COEF)  coefficient ROM address {bank_r, idx}.
REQ-010 SHALL have port rom_data  input  COEFF_SIZE  ROM read data, valid one cycle after rom_addr.
REQ-011 SHALL have port c_we  output  1  interpolator coefficient write enable.
REQ-012 SHALL have port c_addr  output  log2(N_COEF)  interpolator coefficient address.
REQ-013 SHALL have port c_in  output  COEFF_SIZE  interpolator coefficient data, combinationally equal to rom_data.
REQ-014 SHALL have port valid_in  input  1  upstream sample valid.
REQ-015 SHALL have port filt_valid  output  1  gated sample valid to the interpolator.
REQ-016 SHALL have port busy  output  1  high in every state except RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-018 SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-019 SHALL implement states LOAD, DONE, RUN, DRAIN; reset state LOAD with bank_r=0, idx=0 (boot load of bank 0).
REQ-020 In LOAD, idx SHALL increment by 1 per cycle from 0 to N_COEF-1; rom_addr={bank_r, idx}.
REQ-021 c_we and c_addr SHALL be registered: the cycle after LOAD with idx=i, c_we=1 and c_addr=i, aligned with rom_data for address i.
REQ-022 LOAD with idx=N_COEF-1 SHALL transition to DONE; DONE SHALL transition to RUN after one cycle.
REQ-023 done SHALL be high exactly for the single cycle after the last c_we cycle; exactly N_COEF write cycles per load, addresses strictly ascending with no gaps.
REQ-024 filt_valid SHALL equal valid_in when state is RUN and 0 otherwise, combinationally.
REQ-025 start in RUN SHALL be accepted: bank_r<=bank, drain counter<=0, next state DRAIN.
REQ-026 DRAIN SHALL last exactly DRAIN_CYC cycles, then enter LOAD with idx=0.
REQ-027 start in LOAD, DONE or DRAIN SHALL be ignored (bank_r, state, counters unchanged) and err SHALL pulse the next cycle.
REQ-028 valid_in SHALL have no effect on state, counters or c_we.
REQ-029 idx SHALL not wrap; it holds 0 outside LOAD.

Reset
REQ-030 nrst low SHALL asynchronously force: state LOAD, idx 0, bank_r 0, drain counter 0, c_we 0, c_addr 0, done 0, err 0; hence busy 1, filt_valid 0.
REQ-031 nrst asserted mid-load or mid-drain SHALL abort it; after release a full bank-0 load restarts from address 0.

Structure
REQ-032 Shared package SHALL hold the state enumeration and defaults N_COEF, COEFF_SIZE, BANK_W, DRAIN_CYC.
REQ-033 A single sub-module fir_drain_counter (load/enable/terminal-count) SHALL implement the DRAIN timer; the remainder stays flat.

Verification
REQ-034 Reset release, ROM word = address -> c_we high 128 consecutive cycles, c_addr 0..127, c_in 0..127, then done one cycle, busy 0.
REQ-035 valid_in tied 1 during boot -> filt_valid 0 until the cycle after done, then 1.
REQ-036 In RUN, start with bank=2 -> filt_valid 0 for 64+128+1 cycles, rom_addr 256..383, done pulse, filt_valid follows valid_in again.
REQ-037 start during DRAIN and during LOAD -> err pulses once each, bank_r and write sequence unchanged.
REQ-038 nrst pulsed low at c_addr=50 of a bank-3 load -> outputs reset immediately, then a fresh bank-0 load of addresses 0..127.
REQ-039 DRAIN_CYC=1, N_COEF=8 -> start to done spans 1+8+1 cycles, exactly 8 writes.

Source files
------------

// File: rtl/fir_cfg_sequencer_pkg.sv
// Shared definitions for the FIR coefficient reload sequencer: state encoding and
// default sizing used by the top level and by the testbench.
package fir_cfg_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DONE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  localparam int N_COEF_DEF     = 128;
  localparam int COEFF_SIZE_DEF = 16;
  localparam int BANK_W_DEF     = 2;
  localparam int DRAIN_CYC_DEF  = 64;

endpackage

// File: rtl/fir_drain_counter.sv
// Drain timer: cleared by load, counts while enabled, and holds at its terminal
// value. tc is high while the count sits at TERM-1, so an enabled run lasts TERM cycles.
module fir_drain_counter #(
  parameter int TERM  = 64,
  parameter int WIDTH = 7
) (
  input  logic clk,
  input  logic nrst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc = (count_q == WIDTH'(TERM - 1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Coefficient reload sequencer: boots by streaming bank 0 from ROM into the
// interpolator, then reloads a requested bank after draining the data path.
module fir_cfg_sequencer
  import fir_cfg_sequencer_pkg::*;
#(
  parameter int N_COEF     = N_COEF_DEF,
  parameter int COEFF_SIZE = COEFF_SIZE_DEF,
  parameter int BANK_W     = BANK_W_DEF,
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF,
  localparam int IDX_W     = (N_COEF > 1) ? $clog2(N_COEF) : 1,
  localparam int CNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [BANK_W-1:0]       bank,
  output logic [BANK_W+IDX_W-1:0] rom_addr,
  input  logic [COEFF_SIZE-1:0]   rom_data,
  output logic                    c_we,
  output logic [IDX_W-1:0]        c_addr,
  output logic [COEFF_SIZE-1:0]   c_in,
  input  logic                    valid_in,
  output logic                    filt_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  seq_state_t        state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [BANK_W-1:0] bank_q,   bank_d;
  logic              c_we_q,   c_we_d;
  logic [IDX_W-1:0]  c_addr_q, c_addr_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;
  logic              drain_load;
  logic              drain_en;
  logic              drain_tc;

  fir_drain_counter #(
    .TERM  (DRAIN_CYC),
    .WIDTH (CNT_W)
  ) u_drain (
    .clk  (clk),
    .nrst (nrst),
    .load (drain_load),
    .en   (drain_en),
    .tc   (drain_tc)
  );

  // ROM read data lands one cycle after its address, so the write strobe and
  // address are delayed by one register to line up with it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bank_d     = bank_q;
    c_we_d     = 1'b0;
    c_addr_d   = c_addr_q;
    done_d     = 1'b0;
    err_d      = start && (state_q != ST_RUN);
    drain_load = 1'b0;
    drain_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        c_we_d   = 1'b1;
        c_addr_d = idx_q;
        if (idx_q == IDX_W'(N_COEF - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          bank_d     = bank;
          drain_load = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_en = 1'b1;
        if (drain_tc) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      bank_q   <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bank_q   <= bank_d;
      c_we_q   <= c_we_d;
      c_addr_q <= c_addr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rom_addr   = {bank_q, idx_q};
  assign c_in       = rom_data;
  assign c_we       = c_we_q;
  assign c_addr     = c_addr_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_RUN);
  assign filt_valid = (state_q == ST_RUN) && valid_in;

endmodule
